// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer and the datapath it drives.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  // Instruction classes, grouped by the path they take out of EXEC.
  typedef enum logic [2:0] {
    ClsWb      = 3'd0,
    ClsLoad    = 3'd1,
    ClsStore   = 3'd2,
    ClsBranch  = 3'd3,
    ClsIllegal = 3'd4
  } cls_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] ImmNone = 3'b000;
  localparam logic [2:0] ImmI    = 3'b001;
  localparam logic [2:0] ImmS    = 3'b010;
  localparam logic [2:0] ImmB    = 3'b011;
  localparam logic [2:0] ImmJ    = 3'b100;
  localparam logic [2:0] ImmU    = 3'b101;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;

  localparam logic [1:0] WbMem = 2'b00;
  localparam logic [1:0] WbAlu = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;
  localparam logic [1:0] WbImm = 2'b11;

  typedef struct packed {
    logic [2:0] immsel;
    logic       asel;
    logic       bsel;
    logic       brun;
    logic [2:0] alusel;
    logic [1:0] wbsel;
    logic       pcsel;  // jumps redirect the PC in WB
  } ctrl_t;

  // use_lt picks brlt over breq; invert turns eq/lt into ne/ge.
  function automatic logic branch_taken(input logic use_lt, input logic invert,
                                        input logic breq, input logic brlt);
    return (use_lt ? brlt : breq) ^ invert;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the captured opcode/funct3/funct7[5] into the datapath control
// bundle and an instruction class. Unsupported encodings yield ClsIllegal with all controls 0.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output ctrl_t      ctrl,
  output cls_e       cls
);

  always_comb begin
    ctrl = '0;
    cls  = ClsIllegal;
    case (opcode)
      OpReg: begin
        cls        = ClsWb;
        ctrl.wbsel = WbAlu;
        case (funct3)
          3'b000:  ctrl.alusel = funct7b5 ? AluSub : AluAdd;
          3'b111:  ctrl.alusel = AluAnd;
          3'b110:  ctrl.alusel = AluOr;
          3'b100:  ctrl.alusel = AluXor;
          default: cls = ClsIllegal;
        endcase
        if (funct7b5 && (funct3 != 3'b000)) cls = ClsIllegal;
      end
      OpImm: begin
        cls         = ClsWb;
        ctrl.immsel = ImmI;
        ctrl.bsel   = 1'b1;
        ctrl.wbsel  = WbAlu;
        case (funct3)
          3'b000:  ctrl.alusel = AluAdd;
          3'b111:  ctrl.alusel = AluAnd;
          3'b110:  ctrl.alusel = AluOr;
          3'b100:  ctrl.alusel = AluXor;
          default: cls = ClsIllegal;
        endcase
      end
      OpLoad: begin
        ctrl.immsel = ImmI;
        ctrl.bsel   = 1'b1;
        ctrl.wbsel  = WbMem;
        // lb/lh/lw/lbu/lhu; width handling lives in the memory interface
        cls = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ? ClsIllegal : ClsLoad;
      end
      OpStore: begin
        ctrl.immsel = ImmS;
        ctrl.bsel   = 1'b1;
        cls         = (funct3 > 3'b010) ? ClsIllegal : ClsStore;
      end
      OpBranch: begin
        ctrl.immsel = ImmB;
        ctrl.asel   = 1'b1;
        ctrl.bsel   = 1'b1;
        ctrl.brun   = funct3[1];
        cls         = (funct3[2:1] == 2'b01) ? ClsIllegal : ClsBranch;
      end
      OpJal: begin
        cls         = ClsWb;
        ctrl.immsel = ImmJ;
        ctrl.asel   = 1'b1;
        ctrl.bsel   = 1'b1;
        ctrl.wbsel  = WbPc4;
        ctrl.pcsel  = 1'b1;
      end
      OpJalr: begin
        ctrl.immsel = ImmI;
        ctrl.bsel   = 1'b1;
        ctrl.wbsel  = WbPc4;
        ctrl.pcsel  = 1'b1;
        cls         = (funct3 == 3'b000) ? ClsWb : ClsIllegal;
      end
      OpLui: begin
        cls         = ClsWb;
        ctrl.immsel = ImmU;
        ctrl.wbsel  = WbImm;
      end
      OpAuipc: begin
        cls         = ClsWb;
        ctrl.immsel = ImmU;
        ctrl.asel   = 1'b1;
        ctrl.bsel   = 1'b1;
        ctrl.wbsel  = WbAlu;
      end
      default: cls = ClsIllegal;
    endcase
    if (cls == ClsIllegal) ctrl = '0;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes.
// Define CTRL_TRAP_EN to trap on unsupported encodings; otherwise they retire as NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        breq,
  input  logic        brlt,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_wen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        regwen,
  output logic [2:0]  immsel,
  output logic        asel,
  output logic        bsel,
  output logic        brun,
  output logic [2:0]  alusel,
  output logic        pcsel,
  output logic        pc_wen,
  output logic [1:0]  wbsel,
  output logic        illegal
);

  state_e     state_q, state_d;
  logic [6:0] opcode_q;
  logic [2:0] funct3_q;
  logic       funct7b5_q;
  ctrl_t      ctrl;
  cls_e       cls;
  logic       taken;
  logic       unused_ins;

  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};
  assign taken      = branch_taken(funct3_q[2], funct3_q[0], breq, brlt);

  ctrl_decode u_decode (
    .opcode   (opcode_q),
    .funct3   (funct3_q),
    .funct7b5 (funct7b5_q),
    .ctrl     (ctrl),
    .cls      (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else if (state_q == StDecode) begin
      opcode_q   <= ins[6:0];
      funct3_q   <= ins[14:12];
      funct7b5_q <= ins[30];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (imem_ack) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        case (cls)
          ClsLoad, ClsStore: state_d = StMem;
          ClsBranch:         state_d = StFetch;
          ClsWb:             state_d = StWb;
          default: begin
`ifdef CTRL_TRAP_EN
            state_d = StTrap;
`else
            state_d = StFetch;
`endif
          end
        endcase
      end
      StMem:    if (dmem_ack) state_d = (cls == ClsStore) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StTrap: begin
`ifdef CTRL_TRAP_EN
        state_d = StTrap;
`else
        state_d = StFetch;
`endif
      end
      default:  state_d = StFetch;
    endcase
  end

  // Outputs are gated by rst_n so a reset pulse silences every control at once.
  always_comb begin
    imem_req = 1'b0;
    ir_wen   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    regwen   = 1'b0;
    immsel   = ImmNone;
    asel     = 1'b0;
    bsel     = 1'b0;
    brun     = 1'b0;
    alusel   = AluAdd;
    pcsel    = 1'b0;
    pc_wen   = 1'b0;
    wbsel    = WbMem;
    illegal  = 1'b0;
    if (rst_n) begin
      // EXEC controls are held through MEM and WB so the ALU result stays valid.
      if (state_q inside {StExec, StMem, StWb}) begin
        immsel = ctrl.immsel;
        asel   = ctrl.asel;
        bsel   = ctrl.bsel;
        brun   = ctrl.brun;
        alusel = ctrl.alusel;
      end
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_wen   = imem_ack;
        end
        StExec: begin
          if (cls == ClsBranch) begin
            pc_wen = 1'b1;
            pcsel  = taken;
          end
`ifndef CTRL_TRAP_EN
          if (cls == ClsIllegal) pc_wen = 1'b1;
`endif
        end
        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == ClsStore);
          pc_wen   = (cls == ClsStore) && dmem_ack;
        end
        StWb: begin
          regwen = 1'b1;
          pc_wen = 1'b1;
          wbsel  = ctrl.wbsel;
          pcsel  = ctrl.pcsel;
        end
        StTrap: begin
`ifdef CTRL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
